// File: rtl/token_chain.sv
// One-hot token chain: the token position encodes occupancy 0..DEPTH, moved by add/drop
// requests, with registered accept pulses for cascading and sticky reject flags.
module token_chain #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add,
    input  logic             drop,
    output logic             add_ready,
    output logic             drop_ready,
    output logic [DEPTH:0]   token,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             add_out,
    output logic             drop_out,
    output logic             ovf,
    output logic             udf
);

    logic [DEPTH:0]   token_q, token_d;
    logic             add_out_q, add_out_d;
    logic             drop_out_q, drop_out_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             add_acc, drop_acc;
    logic [LVL_W-1:0] level_enc;

    assign empty      = token_q[0];
    assign full       = token_q[DEPTH];
    assign drop_ready = ~empty;
    // A simultaneous drop frees the slot, so a full chain still accepts the add.
    assign add_ready  = ~full | (drop & ~empty);
    assign add_acc    = add & add_ready;
    assign drop_acc   = drop & drop_ready;

    always_comb begin
        level_enc = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (token_q[i]) begin
                level_enc = level_enc | LVL_W'(i);
            end
        end
    end

    always_comb begin
        token_d    = token_q;
        add_out_d  = add_acc;
        drop_out_d = drop_acc;
        ovf_d      = ovf_q | (add & ~add_ready);
        udf_d      = udf_q | (drop & ~drop_ready);
        if (add_acc && !drop_acc) begin
            token_d = {token_q[DEPTH-1:0], 1'b0};
        end else if (drop_acc && !add_acc) begin
            token_d = {1'b0, token_q[DEPTH:1]};
        end
        if (clear) begin
            token_d    = {{DEPTH{1'b0}}, 1'b1};
            add_out_d  = 1'b0;
            drop_out_d = 1'b0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            token_q    <= {{DEPTH{1'b0}}, 1'b1};
            add_out_q  <= 1'b0;
            drop_out_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            token_q    <= token_d;
            add_out_q  <= add_out_d;
            drop_out_q <= drop_out_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign token    = token_q;
    assign level    = level_enc;
    assign add_out  = add_out_q;
    assign drop_out = drop_out_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_token_chain.sv
// Bench for token_chain: an occupancy-counter model checked every cycle for DEPTH=8
// and DEPTH=2 instances, plus hand-computed literal expectations.
module tb_token_chain;

    logic clk = 1'b0;
    logic reset, clear;
    logic add8, drop8, add2, drop2;

    logic       ar8, dr8, emp8, ful8, ao8, do8, ovf8, udf8;
    logic [8:0] tok8;
    logic [3:0] lvl8;
    logic       ar2, dr2, emp2, ful2, ao2, do2, ovf2, udf2;
    logic [2:0] tok2;
    logic [1:0] lvl2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    token_chain #(.DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .add(add8), .drop(drop8),
        .add_ready(ar8), .drop_ready(dr8), .token(tok8), .level(lvl8),
        .empty(emp8), .full(ful8), .add_out(ao8), .drop_out(do8), .ovf(ovf8), .udf(udf8)
    );

    token_chain #(.DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .add(add2), .drop(drop2),
        .add_ready(ar2), .drop_ready(dr2), .token(tok2), .level(lvl2),
        .empty(emp2), .full(ful2), .add_out(ao2), .drop_out(do2), .ovf(ovf2), .udf(udf2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: occupancy as a plain integer per instance
    int m_dep [2] = '{8, 2};
    int m_lvl [2];
    int m_ovf [2];
    int m_udf [2];
    int m_ao  [2];
    int m_do  [2];
    bit m_valid = 1'b0;

    function automatic int m_add_ready(input int k, input logic d);
        return (m_lvl[k] < m_dep[k] || (d && m_lvl[k] > 0)) ? 1 : 0;
    endfunction

    task automatic m_step(input int k, input logic a, input logic d);
        int ar, dr;
        if (reset || clear) begin
            m_lvl[k] = 0; m_ovf[k] = 0; m_udf[k] = 0; m_ao[k] = 0; m_do[k] = 0;
        end else begin
            ar = m_add_ready(k, d);
            dr = (m_lvl[k] > 0) ? 1 : 0;
            m_ao[k] = (a && ar) ? 1 : 0;
            m_do[k] = (d && dr) ? 1 : 0;
            m_lvl[k] = m_lvl[k] + m_ao[k] - m_do[k];
            if (a && !ar) m_ovf[k] = 1;
            if (d && !dr) m_udf[k] = 1;
        end
    endtask

    always @(posedge clk) begin
        m_step(0, add8, drop8);
        m_step(1, add2, drop2);
        if (reset) m_valid = 1'b1;
    end

    task automatic m_cmp(input int k, input logic [8:0] tok, input logic [3:0] lvl,
                         input logic emp, input logic ful, input logic ar, input logic dr,
                         input logic ao, input logic dro, input logic ov, input logic ud,
                         input logic a_in, input logic d_in);
        string p;
        p = (k == 0) ? "d8" : "d2";
        check({p, ".token"}, 32'(tok), 32'(1) << m_lvl[k]);
        check({p, ".onehot"}, 32'($onehot(tok)), 32'd1);
        check({p, ".level"}, 32'(lvl), 32'(m_lvl[k]));
        check({p, ".empty"}, 32'(emp), 32'(m_lvl[k] == 0));
        check({p, ".full"}, 32'(ful), 32'(m_lvl[k] == m_dep[k]));
        check({p, ".add_ready"}, 32'(ar), 32'(m_add_ready(k, d_in)));
        check({p, ".drop_ready"}, 32'(dr), 32'(m_lvl[k] > 0));
        check({p, ".add_out"}, 32'(ao), 32'(m_ao[k]));
        check({p, ".drop_out"}, 32'(dro), 32'(m_do[k]));
        check({p, ".ovf"}, 32'(ov), 32'(m_ovf[k]));
        check({p, ".udf"}, 32'(ud), 32'(m_udf[k]));
        if (a_in === 1'bx) check({p, ".stim"}, 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            m_cmp(0, tok8, lvl8, emp8, ful8, ar8, dr8, ao8, do8, ovf8, udf8, add8, drop8);
            m_cmp(1, {6'd0, tok2}, {2'd0, lvl2}, emp2, ful2, ar2, dr2, ao2, do2, ovf2, udf2,
                  add2, drop2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sweep [16] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11,
                               2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};

    initial begin
        reset = 1'b1; clear = 1'b0;
        add8 = 1'b0; drop8 = 1'b0; add2 = 1'b0; drop2 = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst.token", 32'(tok8), 32'd1);
        check("rst.level", 32'(lvl8), 32'd0);
        check("rst.empty", 32'(emp8), 32'd1);
        check("rst.full", 32'(ful8), 32'd0);
        check("rst.add_ready", 32'(ar8), 32'd1);
        check("rst.drop_ready", 32'(dr8), 32'd0);
        check("rst.flags", 32'({ao8, do8, ovf8, udf8}), 32'd0);

        // Eight adds fill the chain
        add8 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("fill.level", 32'(lvl8), 32'(i));
            check("fill.add_out", 32'(ao8), 32'd1);
        end
        check("fill.full", 32'(ful8), 32'd1);
        check("fill.ovf", 32'(ovf8), 32'd0);

        // Add at full is rejected
        #1;
        check("ovf.add_ready", 32'(ar8), 32'd0);
        step();
        check("ovf.level", 32'(lvl8), 32'd8);
        check("ovf.ovf", 32'(ovf8), 32'd1);
        check("ovf.add_out", 32'(ao8), 32'd0);

        // Down to 3, then simultaneous add/drop for four cycles
        add8 = 1'b0; drop8 = 1'b1;
        repeat (5) step();
        check("drain.level", 32'(lvl8), 32'd3);
        add8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("both.level", 32'(lvl8), 32'd3);
            check("both.outs", 32'({ao8, do8}), 32'd3);
        end
        add8 = 1'b0;
        repeat (3) step();
        check("empty.level", 32'(lvl8), 32'd0);

        // Add and drop while empty
        add8 = 1'b1; drop8 = 1'b1;
        step();
        check("e_both.level", 32'(lvl8), 32'd1);
        check("e_both.udf", 32'(udf8), 32'd1);
        check("e_both.outs", 32'({ao8, do8}), 32'd2);

        // Up to 6 with ovf still set, then clear with add
        drop8 = 1'b0;
        repeat (5) step();
        check("l6.level", 32'(lvl8), 32'd6);
        check("l6.ovf", 32'(ovf8), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr.token", 32'(tok8), 32'd1);
        check("clr.level", 32'(lvl8), 32'd0);
        check("clr.flags", 32'({ao8, do8, ovf8, udf8}), 32'd0);

        // Reset pulse mid-operation at L=5
        repeat (5) step();
        check("l5.level", 32'(lvl8), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0; add8 = 1'b0;
        check("rst5.token", 32'(tok8), 32'd1);
        check("rst5.level", 32'(lvl8), 32'd0);
        check("rst5.flags", 32'({ao8, do8, ovf8, udf8, ful8}), 32'd0);

        // Drop alone while empty
        drop8 = 1'b1;
        step();
        drop8 = 1'b0;
        check("udf.udf", 32'(udf8), 32'd1);
        check("udf.drop_out", 32'(do8), 32'd0);
        check("udf.level", 32'(lvl8), 32'd0);

        // DEPTH=2 sweep through full and empty
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            add2 = sweep[i][1];
            drop2 = sweep[i][0];
            step();
        end
        add2 = 1'b0; drop2 = 1'b0;
        check("sweep.level", 32'(lvl2), 32'd1);
        check("sweep.flags", 32'({ovf2, udf2}), 32'd3);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
